alu_decode_stage: RTL

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_decode_comb.sv | 84 ++++++++
 rtl/alu_decode_stage.sv | 68 ++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes and MIPS opcode/funct constants for the decode
// stage and for users of the 32-bit ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_NOR  = 4'b1010,
    ALU_SLLV = 4'b1011,
    ALU_SRLV = 4'b1100,
    ALU_SRAV = 4'b1101,
    ALU_LUI  = 4'b1110,
    ALU_JR   = 4'b1111
  } alu_f_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational MIPS instruction -> ALU control lookup; unsupported
// encodings flag illegal with all controls forced to their neutral values.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_f_e      alu_f,
  output logic        src_b_imm,
  output logic        imm_zext,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    alu_f     = ALU_ADD;
    src_b_imm = 1'b0;
    imm_zext  = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_f = ALU_ADD;
          FN_SUB, FN_SUBU: alu_f = ALU_SUB;
          FN_AND:          alu_f = ALU_AND;
          FN_OR:           alu_f = ALU_OR;
          FN_XOR:          alu_f = ALU_XOR;
          FN_NOR:          alu_f = ALU_NOR;
          FN_SLL:          alu_f = ALU_SLL;
          FN_SRL:          alu_f = ALU_SRL;
          FN_SRA:          alu_f = ALU_SRA;
          FN_SLLV:         alu_f = ALU_SLLV;
          FN_SRLV:         alu_f = ALU_SRLV;
          FN_SRAV:         alu_f = ALU_SRAV;
          FN_SLT:          alu_f = ALU_SLT;
          FN_SLTU:         alu_f = ALU_SLTU;
          FN_JR:           alu_f = ALU_JR;
          default:         illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        alu_f     = ALU_ADD;
        src_b_imm = 1'b1;
      end
      OP_SLTI: begin
        alu_f     = ALU_SLT;
        src_b_imm = 1'b1;
      end
      OP_SLTIU: begin
        alu_f     = ALU_SLTU;
        src_b_imm = 1'b1;
      end
      OP_ANDI: begin
        alu_f     = ALU_AND;
        src_b_imm = 1'b1;
        imm_zext  = 1'b1;
      end
      OP_ORI: begin
        alu_f     = ALU_OR;
        src_b_imm = 1'b1;
        imm_zext  = 1'b1;
      end
      OP_XORI: begin
        alu_f     = ALU_XOR;
        src_b_imm = 1'b1;
        imm_zext  = 1'b1;
      end
      OP_LUI: begin
        alu_f     = ALU_LUI;
        src_b_imm = 1'b1;
        imm_zext  = 1'b1;
      end
      // Branches compare registers by subtraction, so operand b stays rt.
      OP_BEQ, OP_BNE: alu_f = ALU_SUB;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Single-entry registered decode stage with valid/ready handshake, flush,
// and a saturating counter of accepted illegal instructions.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_f,
  output logic [4:0]       alu_shamt,
  output logic             src_b_imm,
  output logic             imm_zext,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  alu_f_e dec_alu_f;
  logic   dec_src_b_imm;
  logic   dec_imm_zext;
  logic   dec_illegal;
  logic   accept;

  alu_decode_comb u_decode (
    .instr     (instr),
    .alu_f     (dec_alu_f),
    .src_b_imm (dec_src_b_imm),
    .imm_zext  (dec_imm_zext),
    .illegal   (dec_illegal)
  );

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      out_valid     <= 1'b0;
      alu_f         <= 4'b0000;
      alu_shamt     <= 5'd0;
      src_b_imm     <= 1'b0;
      imm_zext      <= 1'b0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_f     <= dec_alu_f;
      alu_shamt <= instr[10:6];
      src_b_imm <= dec_src_b_imm;
      imm_zext  <= dec_imm_zext;
      illegal   <= dec_illegal;
      if (dec_illegal && (illegal_count != '1)) begin
        illegal_count <= illegal_count + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
